// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and scan-code decoder maintaining the 16-bit Hack KBD register.
// The register holds the Hack code of the most recently pressed mapped key until that key is released.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, delivering the byte

module ps2_keyboard #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbd,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_s, dat_s;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] flt_cnt;
  logic          fall, dat;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par_bit, par_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          err_nx, byte_vld;

  logic          ext, brk, lshift, rshift;
  logic [8:0]    held, key;
  logic [7:0]    kbd_lo, code;

  // Filter counts down while the synchronised clock disagrees with the filtered value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= FW'(FILTER_CYCLES - 1);
    end else begin
      clk_s   <= {clk_s[0], ps2_clk};
      dat_s   <= {dat_s[0], ps2_data};
      clk_f_d <= clk_f;
      if (clk_s[1] == clk_f) begin
        flt_cnt <= FW'(FILTER_CYCLES - 1);
      end else if (flt_cnt == '0) begin
        clk_f   <= clk_s[1];
        flt_cnt <= FW'(FILTER_CYCLES - 1);
      end else begin
        flt_cnt <= flt_cnt - 1'b1;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;
  assign dat  = dat_s[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      par_bit   <= par_nx;
      tmo_cnt   <= tmo_nx;
      frame_err <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    tmo_nx     = tmo_cnt;
    err_nx     = 1'b0;
    byte_vld   = 1'b0;
    if (fall) tmo_nx = TW'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0) tmo_nx = tmo_cnt - 1'b1;
    case (state)
      IDLE: if (fall) begin
        if (!dat) begin
          state_nx   = DATA;
          bit_cnt_nx = 3'd0;
        end else begin
          err_nx = 1'b1;
        end
      end
      DATA: if (fall) begin
        shreg_nx   = {dat, shreg[7:1]};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nx = PARITY;
      end
      PARITY: if (fall) begin
        par_nx   = dat;
        state_nx = STOP;
      end
      STOP: if (fall) begin
        state_nx = IDLE;
        if (dat && (^{shreg, par_bit})) byte_vld = 1'b1;
        else err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && !fall && tmo_cnt == '0) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
  end

  function automatic logic [7:0] hack_code(input logic [8:0] k, input logic sh);
    logic [7:0] c;
    c = 8'd0;
    case (k)
      9'h01C: c = sh ? "A" : "a";   9'h032: c = sh ? "B" : "b";
      9'h021: c = sh ? "C" : "c";   9'h023: c = sh ? "D" : "d";
      9'h024: c = sh ? "E" : "e";   9'h02B: c = sh ? "F" : "f";
      9'h034: c = sh ? "G" : "g";   9'h033: c = sh ? "H" : "h";
      9'h043: c = sh ? "I" : "i";   9'h03B: c = sh ? "J" : "j";
      9'h042: c = sh ? "K" : "k";   9'h04B: c = sh ? "L" : "l";
      9'h03A: c = sh ? "M" : "m";   9'h031: c = sh ? "N" : "n";
      9'h044: c = sh ? "O" : "o";   9'h04D: c = sh ? "P" : "p";
      9'h015: c = sh ? "Q" : "q";   9'h02D: c = sh ? "R" : "r";
      9'h01B: c = sh ? "S" : "s";   9'h02C: c = sh ? "T" : "t";
      9'h03C: c = sh ? "U" : "u";   9'h02A: c = sh ? "V" : "v";
      9'h01D: c = sh ? "W" : "w";   9'h022: c = sh ? "X" : "x";
      9'h035: c = sh ? "Y" : "y";   9'h01A: c = sh ? "Z" : "z";
      9'h045: c = sh ? ")" : "0";   9'h016: c = sh ? "!" : "1";
      9'h01E: c = sh ? "@" : "2";   9'h026: c = sh ? "#" : "3";
      9'h025: c = sh ? "$" : "4";   9'h02E: c = sh ? "%" : "5";
      9'h036: c = sh ? "^" : "6";   9'h03D: c = sh ? "&" : "7";
      9'h03E: c = sh ? "*" : "8";   9'h046: c = sh ? "(" : "9";
      9'h00E: c = sh ? "~" : 8'd96; 9'h04E: c = sh ? "_" : "-";
      9'h055: c = sh ? "+" : "=";   9'h054: c = sh ? "{" : "[";
      9'h05B: c = sh ? "}" : "]";   9'h05D: c = sh ? 8'd124 : 8'd92;
      9'h04C: c = sh ? ":" : ";";   9'h052: c = sh ? 8'd34 : 8'd39;
      9'h041: c = sh ? "<" : ",";   9'h049: c = sh ? ">" : ".";
      9'h04A: c = sh ? "?" : "/";   9'h029: c = 8'd32;
      9'h05A: c = 8'd128;  9'h066: c = 8'd129;  9'h076: c = 8'd140;
      9'h16B: c = 8'd130;  9'h175: c = 8'd131;  9'h174: c = 8'd132;
      9'h172: c = 8'd133;  9'h16C: c = 8'd134;  9'h169: c = 8'd135;
      9'h17D: c = 8'd136;  9'h17A: c = 8'd137;  9'h170: c = 8'd138;
      9'h171: c = 8'd139;
      9'h005: c = 8'd141;  9'h006: c = 8'd142;  9'h004: c = 8'd143;
      9'h00C: c = 8'd144;  9'h003: c = 8'd145;  9'h00B: c = 8'd146;
      9'h083: c = 8'd147;  9'h00A: c = 8'd148;  9'h001: c = 8'd149;
      9'h009: c = 8'd150;  9'h078: c = 8'd151;  9'h007: c = 8'd152;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  assign key  = {ext, shreg};
  assign code = hack_code(key, lshift | rshift);

  // A break only clears kbd when it matches the key that loaded it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      held      <= '0;
      kbd_lo    <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_vld) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            if (key == 9'h012) lshift <= 1'b0;
            else if (key == 9'h059) rshift <= 1'b0;
            else if (key == held) begin
              kbd_lo <= '0;
              held   <= '0;
            end
          end else begin
            if (key == 9'h012) lshift <= 1'b1;
            else if (key == 9'h059) rshift <= 1'b1;
            else if (code != 8'd0) begin
              kbd_lo    <= code;
              held      <= key;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign kbd = {8'h00, kbd_lo};

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks kbd and pulse counts.
module tb_ps2_keyboard;

  localparam int TMO = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] kbd;
  logic        key_valid, frame_err;

  int n_assert = 0;
  int n_fail = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int kv0, fe0;

  ps2_keyboard #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd(kbd), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch = 0);
    ps2_data = b;
    wait_clk(20);
    ps2_clk = 1'b0;
    wait_clk(40);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_clk(16);
      ps2_clk = 1'b0;
      wait_clk(4);
      ps2_clk = 1'b1;
      wait_clk(20);
    end else begin
      wait_clk(20);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                            input bit bad_stop = 0, input int glitch_bit = -1);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(fr[i], i == glitch_bit);
    ps2_data = 1'b1;
    wait_clk(20);
    @(negedge clk);
  endtask

  task automatic brk(input logic [7:0] b);
    send_frame(8'hF0);
    send_frame(b);
  endtask

  initial begin
    wait_clk(5);
    @(negedge clk);
    check("rst_kbd", kbd, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    wait_clk(20);

    kv0 = kv_cnt;
    send_frame(8'h1C);
    check("make_a_kbd", kbd, 97);
    check("make_a_pulses", kv_cnt - kv0, 1);
    kv0 = kv_cnt;
    brk(8'h1C);
    check("break_a_kbd", kbd, 0);
    check("break_a_pulses", kv_cnt - kv0, 0);

    send_frame(8'h12);
    check("lshift_make_kbd", kbd, 0);
    send_frame(8'h1C);
    check("shift_a_kbd", kbd, 65);
    brk(8'h12);
    check("shift_break_hold", kbd, 65);
    brk(8'h1C);
    check("shift_a_release", kbd, 0);

    send_frame(8'hE0);
    send_frame(8'h75);
    check("up_kbd", kbd, 131);
    send_frame(8'hE0);
    brk(8'h75);
    check("up_release", kbd, 0);

    send_frame(8'h1C);
    kv0 = kv_cnt;
    send_frame(8'h75);
    check("kp8_unmapped_kbd", kbd, 97);
    check("kp8_unmapped_pulses", kv_cnt - kv0, 0);

    kv0 = kv_cnt;
    send_frame(8'h1C);
    send_frame(8'h1C);
    check("typematic_kbd", kbd, 97);
    check("typematic_pulses", kv_cnt - kv0, 2);
    send_frame(8'h29);
    check("space_kbd", kbd, 32);
    brk(8'h1C);
    check("old_break_ignored", kbd, 32);
    brk(8'h29);
    check("space_release", kbd, 0);

    send_frame(8'h59);
    send_frame(8'h16);
    check("rshift_1_kbd", kbd, 33);
    brk(8'h16);
    brk(8'h59);
    send_frame(8'h16);
    check("digit_1_kbd", kbd, 49);
    brk(8'h16);

    send_frame(8'h07);
    check("f12_kbd", kbd, 152);
    send_frame(8'hE0);
    send_frame(8'h71);
    check("delete_kbd", kbd, 139);
    brk(8'h07);
    check("f12_break_ignored", kbd, 139);
    send_frame(8'hE0);
    brk(8'h71);
    check("delete_release", kbd, 0);

    send_frame(8'h1C);
    fe0 = fe_cnt;
    kv0 = kv_cnt;
    send_frame(8'h16, 1);
    check("bad_parity_err", fe_cnt - fe0, 1);
    check("bad_parity_kbd", kbd, 97);
    fe0 = fe_cnt;
    send_frame(8'h16, 0, 1);
    check("bad_stop_err", fe_cnt - fe0, 1);
    check("bad_stop_kbd", kbd, 97);
    check("bad_frames_pulses", kv_cnt - kv0, 0);
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    wait_clk(20);
    check("bad_start_err", fe_cnt - fe0, 1);

    fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_clk(TMO + 200);
    check("timeout_err", fe_cnt - fe0, 1);
    kv0 = kv_cnt;
    send_frame(8'h5A);
    check("enter_after_timeout", kbd, 128);
    check("enter_pulses", kv_cnt - kv0, 1);

    fe0 = fe_cnt;
    send_frame(8'h66, 0, 0, 4);
    check("glitch_backspace_kbd", kbd, 129);
    check("glitch_no_err", fe_cnt - fe0, 0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midframe_reset_kbd", kbd, 0);
    wait_clk(5);
    @(negedge clk);
    reset = 1'b1;
    wait_clk(100);
    check("midframe_reset_kv", kv_cnt - kv0, 0);
    check("midframe_reset_fe", fe_cnt - fe0, 0);
    send_frame(8'h1C);
    check("post_reset_kbd", kbd, 97);
    check("post_reset_pulses", kv_cnt - kv0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Input-side counterpart to the VGA display path: receives PS/2 keyboard frames and maintains the 16-bit Hack keyboard register.
- The memory map's KBD word (address 24576) reads this register; value is the Hack code of the currently held key, 0 when none.
- Sits beside the VGA controller at the Hack top level on the same clk.
- Contains a PS/2 frame receiver, scan-code decoder (E0/F0 prefixes, shift tracking) and held-key logic.

Parameters:
- FILTER_CYCLES, 8: consecutive identical synchronised samples required before ps2_clk changes its filtered value.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge that abort a partial frame (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- kbd  out  16  Hack keyboard register; bits [15:8] always 0.
- key_valid  out  1  one-cycle pulse when kbd is loaded by a mapped make code.
- frame_err  out  1  one-cycle pulse on bad start, parity, stop, or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - kbd=0, key_valid=0, frame_err=0.
  - Frame FSM goes to IDLE; prefix flags, shift flags and held-code register clear.
  - Filtered ps2_clk is forced to 1.
  - Reset asserted mid-frame discards the partial frame; no pulse is generated.
- Input conditioning:
  - 2-FF synchronisers on ps2_clk and ps2_data.
  - Glitch filter on ps2_clk: output changes only after FILTER_CYCLES equal samples.
  - Data is sampled on the filtered falling edge.
- Frame FSM:
  - IDLE: on a falling edge, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first; after 8 bits go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: require data=1 and odd parity over the 8 data bits plus parity bit. Pass: deliver the byte to the decoder in the same cycle and return to IDLE. Fail: pulse frame_err and return to IDLE.
  - Timeout: in DATA, PARITY or STOP, a counter reaching TIMEOUT_CYCLES since the last edge sends the FSM to IDLE and pulses frame_err. The counter resets on each edge.
  - Host-to-device transmission is not supported; ps2_clk and ps2_data are inputs only.
- Decoder (acts on each delivered byte):
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: form key = {ext, byte}, then clear ext and brk after processing.
  - Break with key 0x12 or 0x59: clear that shift flag.
  - Other break: if key equals the held code, kbd=0 and held code is cleared; otherwise no change.
  - Make with key 0x12 or 0x59: set that shift flag; kbd unchanged.
  - Other make: look up the Hack code using shift = lshift OR rshift. If nonzero, load kbd, store key as held code, pulse key_valid. If unmapped, no change.
- Map:
  - Letters: 65–90 when shifted, 97–122 when unshifted (A=0x1C, Z=0x1A).
  - Digits and US punctuation: standard ASCII, shift-aware (0x16 gives 49 or 33).
  - Space 0x29 gives 32.
  - Enter 0x5A=128, Backspace 0x66=129, Esc 0x76=140.
  - Left E0 6B=130, Up E0 75=131, Right E0 74=132, Down E0 72=133.
  - Home E0 6C=134, End E0 69=135, PgUp E0 7D=136, PgDn E0 7A=137.
  - Insert E0 70=138, Delete E0 71=139.
  - F1–F12 give 141–152 (F1=0x05, F12=0x07).
- Latency: kbd and key_valid update exactly 1 clk after the STOP-bit falling edge is detected.
- kbd holds its latched value while a shift key is pressed or released afterwards.
- Typematic repeat of the held key reloads the same value and pulses key_valid again.
- A new make while another key is held replaces kbd and the held code. The old key's later break is ignored.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> kbd=97 and a single key_valid pulse; then F0 1C -> kbd=0 with no key_valid.
- Make 12, make 1C, break F0 12, break F0 1C -> kbd=65 after 1C and still 65 after the shift break; 0 after the 1C break.
- E0 75 then E0 F0 75 -> kbd=131 then 0. Plain 0x75 (keypad 8) -> unmapped, kbd unchanged.
- Make 1C, make 29, break F0 1C -> kbd=97, then 32, and remains 32.
- Frame with flipped parity bit -> frame_err pulse, kbd unchanged. Stop bit 0 -> frame_err. 4 bits then ps2_clk idle for TIMEOUT_CYCLES -> frame_err, then next valid frame 0x5A decodes to kbd=128.
- ps2_clk glitch shorter than FILTER_CYCLES mid-frame -> ignored, byte still decodes. Reset pulled low mid-frame -> kbd=0 immediately with no pulses, and the following frame decodes cleanly.
